byte_serial_adder: RTL and testbench



---
 rtl/byte_serial_adder.sv | 217 +++++++++++++++++++++
 tb/tb_byte_serial_adder.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_serial_adder.sv
// byte_serial_adder: WIDTH-bit add/subtract computed one byte per cycle,
// least-significant byte first, through a single 8-bit conditional-sum adder.
// The carry between bytes is held in carry_r, so the combinational carry chain
// never spans more than eight bits. Operands and results use valid/ready
// handshakes; in_ready and out_valid are decoded from the state register only.

// 8-bit conditional-sum adder. Every bit position computes its sum and carry
// for both possible carry-ins; blocks are then merged pairwise (1 -> 2 -> 4 -> 8
// bits). Each merge picks the upper block's precomputed pair using the lower
// block's carry, so the carry-in only steers the final 2:1 selection.
module conditional_sum_adder (
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    // Index [l] is merge level l (block size 2**l). s0/c0 assume a block
    // carry-in of 0, s1/c1 a carry-in of 1. c*[l][j] is the carry out of block j.
    logic [3:0][7:0] s0;
    logic [3:0][7:0] s1;
    logic [3:0][7:0] c0;
    logic [3:0][7:0] c1;

    // Build both conditional results bottom-up, then pick one with cin.
    always_comb begin
        // NOTE: every variable gets a default before any branch or loop so no
        // path leaves it unassigned, which would otherwise infer a latch.
        s0   = '0;
        s1   = '0;
        c0   = '0;
        c1   = '0;
        sum  = '0;
        cout = 1'b0;

        // Level 0: single-bit blocks.
        s0[0] = x ^ y;
        s1[0] = ~(x ^ y);
        c0[0] = x & y;
        c1[0] = x | y;

        for (int l = 1; l < 4; l++) begin
            // Sum bits: the lower half of each merged block passes through, the
            // upper half selects on the lower half's carry.
            for (int bt = 0; bt < 8; bt++) begin
                if (((bt >> (l - 1)) & 1) == 0) begin
                    s0[l][bt] = s0[l-1][bt];
                    s1[l][bt] = s1[l-1][bt];
                end else begin
                    s0[l][bt] = c0[l-1][(bt >> l) * 2] ? s1[l-1][bt] : s0[l-1][bt];
                    s1[l][bt] = c1[l-1][(bt >> l) * 2] ? s1[l-1][bt] : s0[l-1][bt];
                end
            end
            // Block carries: the lower block's carry selects the upper block's.
            for (int j = 0; j < (8 >> l); j++) begin
                c0[l][j] = c0[l-1][2*j] ? c1[l-1][2*j+1] : c0[l-1][2*j+1];
                c1[l][j] = c1[l-1][2*j] ? c1[l-1][2*j+1] : c0[l-1][2*j+1];
            end
        end

        sum  = cin ? s1[3] : s0[3];
        cout = cin ? c1[3][0] : c0[3][0];
    end

endmodule

module byte_serial_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int N     = WIDTH / 8;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    // Widths that are not a whole number of bytes cannot be stepped bytewise.
    generate
        if (WIDTH < 8 || (WIDTH % 8) != 0) begin : g_bad_width
            $error("byte_serial_adder: WIDTH must be a multiple of 8 and at least 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;

    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   sum_r;
    logic               carry_r;
    logic               msb_a;
    logic               msb_b;
    logic [CNT_W-1:0]   cnt;

    logic               accept;
    logic               last_step;
    logic [WIDTH-1:0]   b_in;
    logic [WIDTH-1:0]   a_shift;
    logic [WIDTH-1:0]   b_shift;
    logic [WIDTH-1:0]   sum_shift;
    logic [7:0]         add_sum;
    logic               add_cout;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid && in_ready;
    assign last_step = (cnt == CNT_W'(N - 1));

    // Subtraction is A + ~B + 1: B is inverted on capture, the +1 is carry_r.
    assign b_in = sub ? ~b : b;

    // The byte adder always works on the low byte of the shifting operands.
    conditional_sum_adder u_csa (
        .x    (a_r[7:0]),
        .y    (b_r[7:0]),
        .cin  (carry_r),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Operands drain towards bit 0; results enter sum_r from the top so that
    // after N steps the first byte computed lands in sum_r[7:0].
    generate
        if (WIDTH == 8) begin : g_one_byte
            assign a_shift   = '0;
            assign b_shift   = '0;
            assign sum_shift = add_sum;
        end else begin : g_multi_byte
            assign a_shift   = {8'h00, a_r[WIDTH-1:8]};
            assign b_shift   = {8'h00, b_r[WIDTH-1:8]};
            assign sum_shift = {add_sum, sum_r[WIDTH-1:8]};
        end
    endgenerate

    // Result ports come straight from registers, so they hold steady in DONE.
    assign sum      = sum_r;
    assign cout     = carry_r;
    assign overflow = (msb_a ~^ msb_b) & (sum_r[WIDTH-1] ^ msb_a);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode: accept in IDLE, N byte steps in RUN, hold DONE until taken.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last_step) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Operand capture on acceptance and one byte step per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every datapath register is reset, not just the control state,
        // because sum/cout/overflow must read zero out of reset and an aborted
        // operation must leave no partial result visible.
        if (!rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            carry_r <= 1'b0;
            msb_a   <= 1'b0;
            msb_b   <= 1'b0;
            cnt     <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_r     <= a;
                        b_r     <= b_in;
                        carry_r <= sub;
                        msb_a   <= a[WIDTH-1];
                        msb_b   <= b_in[WIDTH-1];
                        cnt     <= '0;
                    end
                end
                RUN: begin
                    a_r     <= a_shift;
                    b_r     <= b_shift;
                    sum_r   <= sum_shift;
                    carry_r <= add_cout;
                    cnt     <= cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_byte_serial_adder.sv
// Testbench for byte_serial_adder: a 32-bit and an 8-bit instance share clock
// and reset. A per-cycle monitor compares both against an arithmetic model of
// the add/subtract result and the handshake timing; directed sequences on the
// 32-bit instance pin hand-computed values.
module tb_byte_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        in_valid, in_ready, sub, out_valid, out_ready, cout, overflow;
    logic [31:0] a, b, sum;

    logic        in_valid8, in_ready8, sub8, out_valid8, out_ready8, cout8, overflow8;
    logic [7:0]  a8, b8, sum8;

    int          n_checks = 0;
    int          n_errors = 0;

    // Monitor state per port: 0 = 32-bit instance, 1 = 8-bit instance.
    bit          busy [2];
    int          age  [2];
    logic [33:0] exp_r[2];
    int          nacc [2];
    int          nres [2];

    always #5 clk = ~clk;

    byte_serial_adder #(.WIDTH(32)) dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow)
    );

    byte_serial_adder #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .sub       (sub8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .sum       (sum8),
        .cout      (cout8),
        .overflow  (overflow8)
    );

    // Reference result {overflow, cout, sum} from plain integer arithmetic.
    function automatic logic [33:0] model(input logic [31:0] ua_i, input logic [31:0] ub_i,
                                          input logic s, input int w);
        longint m, hs, ua, ub, sa, sb, r, rs;
        logic   c, v;
        logic [31:0] s_out;
        m     = longint'(1) << w;
        hs    = m / 2;
        ua    = longint'(ua_i) & (m - 1);
        ub    = longint'(ub_i) & (m - 1);
        sa    = (ua >= hs) ? ua - m : ua;
        sb    = (ub >= hs) ? ub - m : ub;
        r     = s ? ua - ub : ua + ub;
        s_out = 32'(((r % m) + m) % m);
        c     = s ? (ua >= ub) : (r >= m);
        rs    = s ? sa - sb : sa + sb;
        v     = (rs < -hs) || (rs >= hs);
        return {v, c, s_out};
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    // One cycle of the monitor for one port, sampled at the falling edge.
    task automatic mon(input int p, input int w, input logic rst_ni,
                       input logic iv, input logic ir, input logic [31:0] ia,
                       input logic [31:0] ib, input logic is, input logic ov,
                       input logic ordy, input logic [31:0] os, input logic oc,
                       input logic oo);
        string tag;
        tag = (p == 0) ? "w32" : "w8";
        if (!rst_ni) begin
            check({tag, ".rst.in_ready"},  64'(ir), 64'(1));
            check({tag, ".rst.out_valid"}, 64'(ov), 64'(0));
            check({tag, ".rst.sum"},       64'(os), 64'(0));
            check({tag, ".rst.cout"},      64'(oc), 64'(0));
            check({tag, ".rst.overflow"},  64'(oo), 64'(0));
            busy[p] = 1'b0;
            age[p]  = 0;
        end else begin
            if (busy[p]) age[p]++;
            check({tag, ".in_ready"},  64'(ir), 64'(!busy[p]));
            check({tag, ".out_valid"}, 64'(ov), 64'(busy[p] && (age[p] >= w / 8 + 1)));
            if (ov) begin
                check({tag, ".sum"},      64'(os), 64'(exp_r[p][31:0]));
                check({tag, ".cout"},     64'(oc), 64'(exp_r[p][32]));
                check({tag, ".overflow"}, 64'(oo), 64'(exp_r[p][33]));
                if (ordy) begin
                    busy[p] = 1'b0;
                    nres[p]++;
                end
            end
            if (iv && ir) begin
                exp_r[p] = model(ia, ib, is, w);
                busy[p]  = 1'b1;
                age[p]   = 0;
                nacc[p]++;
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, 32, rst_n, in_valid, in_ready, a, b, sub, out_valid, out_ready,
            sum, cout, overflow);
        mon(1, 8, rst_n, in_valid8, in_ready8, {24'h0, a8}, {24'h0, b8}, sub8,
            out_valid8, out_ready8, {24'h0, sum8}, cout8, overflow8);
    end

    // Wait (bounded) for out_valid on the 32-bit port, counting edges since entry.
    task automatic wait_out(input string nm, output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({nm, ".out_valid_seen"}, 64'(out_valid), 64'(1));
    endtask

    // Directed operation on the 32-bit port with literal expectations.
    task automatic run_op(input string nm, input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic ts, input logic [31:0] es, input logic ec,
                          input logic ev);
        int lat;
        check({nm, ".model"}, 64'(model(ta, tb_v, ts, 32)), 64'({ev, ec, es}));
        check({nm, ".idle"}, 64'(in_ready), 64'(1));
        in_valid  = 1'b1;
        a         = ta;
        b         = tb_v;
        sub       = ts;
        out_ready = 1'b1;
        @(posedge clk); #1;          // acceptance edge E0
        in_valid = 1'b0;
        a        = $urandom;         // scrambled operands must not disturb the op
        b        = $urandom;
        sub      = 1'($urandom_range(1));
        wait_out(nm, lat);
        check({nm, ".latency"},  64'(lat), 64'(4));
        check({nm, ".sum"},      64'(sum), 64'(es));
        check({nm, ".cout"},     64'(cout), 64'(ec));
        check({nm, ".overflow"}, 64'(overflow), 64'(ev));
        @(posedge clk); #1;          // result handshake edge
        check({nm, ".back_idle"}, 64'(in_ready), 64'(1));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int cyc;
        rst_n      = 1'b0;
        in_valid   = 1'b0; a  = '0; b  = '0; sub  = 1'b0; out_ready  = 1'b0;
        in_valid8  = 1'b0; a8 = '0; b8 = '0; sub8 = 1'b0; out_ready8 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset during the second RUN cycle discards the operation.
        in_valid  = 1'b1;
        a         = 32'h0101_0101;
        b         = 32'h0202_0202;
        sub       = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;          // accepted, first RUN cycle
        in_valid = 1'b0;
        @(posedge clk); #1;          // second RUN cycle
        rst_n = 1'b0;
        #1;
        check("rst_mid.in_ready",  64'(in_ready),  64'(1));
        check("rst_mid.out_valid", 64'(out_valid), 64'(0));
        check("rst_mid.sum",       64'(sum),       64'(0));
        check("rst_mid.cout",      64'(cout),      64'(0));
        check("rst_mid.overflow",  64'(overflow),  64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("rst_mid.no_result", 64'(out_valid), 64'(0));
            @(posedge clk); #1;
        end

        // Directed arithmetic cases.
        run_op("add_carry",  32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
        run_op("add_wrap",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        run_op("add_ovf",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        run_op("sub_borrow", 32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_op("sub_ovf",    32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

        // Backpressure: DONE holds while new operands are offered.
        in_valid  = 1'b1;
        a         = 32'h1234_5678;
        b         = 32'h1111_1111;
        sub       = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        a   = 32'h0000_0010;
        b   = 32'h0000_0020;
        sub = 1'b1;
        wait_out("bp", lat);
        check("bp.latency", 64'(lat), 64'(4));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("bp.hold.out_valid", 64'(out_valid), 64'(1));
            check("bp.hold.in_ready",  64'(in_ready),  64'(0));
            check("bp.hold.sum",       64'(sum),       64'(32'h2345_6789));
            check("bp.hold.cout",      64'(cout),      64'(0));
            check("bp.hold.overflow",  64'(overflow),  64'(0));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp.release.in_ready",  64'(in_ready),  64'(1));
        check("bp.release.out_valid", 64'(out_valid), 64'(0));
        @(posedge clk); #1;
        check("bp.pending_taken", 64'(in_ready), 64'(0));
        in_valid = 1'b0;
        wait_out("bp2", lat);
        check("bp2.latency",  64'(lat),      64'(4));
        check("bp2.sum",      64'(sum),      64'(32'hFFFF_FFF0));
        check("bp2.cout",     64'(cout),     64'(0));
        check("bp2.overflow", 64'(overflow), 64'(0));
        @(posedge clk); #1;

        // Random regression on both widths with random handshake gaps.
        nacc[0] = 0; nres[0] = 0;
        nacc[1] = 0; nres[1] = 0;
        cyc = 0;
        while ((nacc[0] < 5000 || nacc[1] < 5000) && cyc < 80000) begin
            in_valid   = ($urandom_range(7) != 0);
            a          = ($urandom_range(7) == 0) ? 32'h7FFF_FFFF << $urandom_range(1) : $urandom;
            b          = ($urandom_range(7) == 0) ? 32'hFFFF_FFFF : $urandom;
            sub        = 1'($urandom_range(1));
            out_ready  = ($urandom_range(3) != 0);
            in_valid8  = ($urandom_range(7) != 0);
            a8         = 8'($urandom);
            b8         = ($urandom_range(7) == 0) ? 8'h80 : 8'($urandom);
            sub8       = 1'($urandom_range(1));
            out_ready8 = ($urandom_range(3) != 0);
            @(posedge clk); #1;
            cyc++;
        end
        check("rand.ops32", 64'(nacc[0] >= 5000), 64'(1));
        check("rand.ops8",  64'(nacc[1] >= 5000), 64'(1));

        // Drain and confirm every accepted operation produced exactly one result.
        in_valid   = 1'b0;
        in_valid8  = 1'b0;
        out_ready  = 1'b1;
        out_ready8 = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("drain.busy32",  64'(busy[0]), 64'(0));
        check("drain.busy8",   64'(busy[1]), 64'(0));
        check("drain.count32", 64'(nres[0]), 64'(nacc[0]));
        check("drain.count8",  64'(nres[1]), 64'(nacc[1]));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
